// File: rtl/token_bucket_pkg.sv
// Shared defaults and bucket sizing helpers for the multi-channel token bucket.
package token_bucket_pkg;

   localparam int unsigned NCH_DEF       = 4;
   localparam int unsigned DEN_DEF       = 16;
   localparam int unsigned BURST_MAX_DEF = 8;
   localparam int unsigned RATE_W_DEF    = 8;
   localparam int unsigned COST_W_DEF    = 8;
   localparam int unsigned STAT_W        = 16;

   function automatic int unsigned tok_max_f(input int unsigned burst_max,
                                             input int unsigned den);
      return burst_max * den;
   endfunction

   function automatic int unsigned tok_w_f(input int unsigned tok_max);
      return $clog2(tok_max + 1);
   endfunction

endpackage

// File: rtl/token_bucket_chan.sv
// One token bucket: saturating refill, eligibility compare and debit on grant.
module token_bucket_chan
   import token_bucket_pkg::*;
#(
   parameter int unsigned TOK_MAX = 128,
   parameter int unsigned RATE_W  = 8,
   parameter int unsigned COST_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [RATE_W-1:0] rate_i,
   input  logic [COST_W-1:0] cost_i,
   input  logic              debit_i,
   output logic              ready_o,
   output logic              elig_o
);

   localparam int unsigned TOK_W  = tok_w_f(TOK_MAX);
   localparam int unsigned POST_W = TOK_W + 1;
   localparam int unsigned SUM_W  = ((TOK_W > RATE_W) ? TOK_W : RATE_W) + 1;
   localparam int unsigned CMP_W  = (POST_W > COST_W) ? POST_W : COST_W;
   localparam logic [SUM_W-1:0] TOK_MAX_S = SUM_W'(TOK_MAX);

   logic [TOK_W-1:0]  tokens_q, tokens_d;
   logic [SUM_W-1:0]  sum;
   logic [POST_W-1:0] post;
   logic [CMP_W-1:0]  post_c, cost_c;

   // Sum is wide enough for any rate, so the clamp sees the true total.
   always_comb begin
      sum      = SUM_W'(tokens_q) + SUM_W'(rate_i);
      post     = (sum > TOK_MAX_S) ? POST_W'(TOK_MAX) : POST_W'(sum);
      post_c   = CMP_W'(post);
      cost_c   = CMP_W'(cost_i);
      ready_o  = (post_c >= cost_c);
      elig_o   = req_i & ready_o;
      tokens_d = TOK_W'(post);
      if (debit_i) begin
         tokens_d = TOK_W'(post_c - cost_c);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tokens_q <= TOK_W'(TOK_MAX);
      end else begin
         tokens_q <= tokens_d;
      end
   end

endmodule

// File: rtl/mc_token_bucket.sv
// Multi-channel token-bucket rate limiter with round-robin grant arbitration.
// Define TOKEN_BUCKET_STATS_EN to enable the per-channel saturating grant counters.
module mc_token_bucket
   import token_bucket_pkg::*;
#(
   parameter int unsigned NCH       = NCH_DEF,
   parameter int unsigned DEN       = DEN_DEF,
   parameter int unsigned BURST_MAX = BURST_MAX_DEF,
   parameter int unsigned RATE_W    = RATE_W_DEF,
   parameter int unsigned COST_W    = COST_W_DEF
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NCH-1:0]                             req_i,
   input  logic [NCH*RATE_W-1:0]                      rate_i,
   input  logic [NCH*COST_W-1:0]                      cost_i,
   output logic [NCH-1:0]                             grant_o,
   output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]   grant_id_o,
   output logic [NCH-1:0]                             ready_o,
   output logic [NCH*STAT_W-1:0]                      stat_cnt_o
);

   localparam int unsigned ID_W    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned TOK_MAX = tok_max_f(BURST_MAX, DEN);

   logic [NCH-1:0]  elig, win;
   logic [ID_W-1:0] rr_q, rr_d, sel;
   logic            found;
   logic [NCH-1:0]  grant_q;
   logic [ID_W-1:0] grant_id_q;
   int unsigned     idx;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      token_bucket_chan #(
         .TOK_MAX (TOK_MAX),
         .RATE_W  (RATE_W),
         .COST_W  (COST_W)
      ) u_chan (
         .clk     (clk),
         .rst     (rst),
         .req_i   (req_i[i]),
         .rate_i  (rate_i[i*RATE_W +: RATE_W]),
         .cost_i  (cost_i[i*COST_W +: COST_W]),
         .debit_i (win[i]),
         .ready_o (ready_o[i]),
         .elig_o  (elig[i])
      );
   end

   // First eligible channel scanning upward from rr_q with wrap.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         idx = (32'(rr_q) + k) % NCH;
         if (!found && elig[idx]) begin
            found = 1'b1;
            sel   = ID_W'(idx);
         end
      end
      win = '0;
      if (found) begin
         win[sel] = 1'b1;
      end
      rr_d = rr_q;
      if (found) begin
         rr_d = (sel == ID_W'(NCH - 1)) ? '0 : sel + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q       <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
      end else begin
         rr_q       <= rr_d;
         grant_q    <= win;
         grant_id_q <= sel;
      end
   end

   assign grant_o    = grant_q;
   assign grant_id_o = grant_id_q;

`ifdef TOKEN_BUCKET_STATS_EN
   logic [NCH-1:0][STAT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (win[i] && (cnt_q[i] != {STAT_W{1'b1}})) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign stat_cnt_o = cnt_q;
`else
   assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mc_token_bucket.sv
// Scoreboard bench for mc_token_bucket: directed scenarios push expected grants,
// a negedge monitor pops and compares whenever the DUT presents a grant.
module tb_mc_token_bucket;

   localparam int NCH    = 4;
   localparam int RATE_W = 8;
   localparam int COST_W = 8;

   typedef struct {
      int cyc;
      int id;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       req_i;
   logic [NCH*RATE_W-1:0] rate_i;
   logic [NCH*COST_W-1:0] cost_i;
   logic [NCH-1:0]       grant_o;
   logic [1:0]           grant_id_o;
   logic [NCH-1:0]       ready_o;
   logic [NCH*16-1:0]    stat_cnt_o;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   base;
   int   exp_cnt[NCH];

   mc_token_bucket #(
      .NCH       (4),
      .DEN       (16),
      .BURST_MAX (8),
      .RATE_W    (RATE_W),
      .COST_W    (COST_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .rate_i     (rate_i),
      .cost_i     (cost_i),
      .grant_o    (grant_o),
      .grant_id_o (grant_id_o),
      .ready_o    (ready_o),
      .stat_cnt_o (stat_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_grant(input int c, input int id);
      exp_t t;
      t.cyc = c;
      t.id  = id;
      q.push_back(t);
      exp_cnt[id]++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst   = 1'b1;
      req_i = '0;
      #1;
      chk("rst_grant", grant_o, 0);
      chk("rst_grant_id", grant_id_o, 0);
      chk("rst_stat", stat_cnt_o, 0);
      for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
      #1;
      rst = 1'b0;
   endtask

   task automatic check_stats;
      for (int i = 0; i < NCH; i++) begin
`ifdef TOKEN_BUCKET_STATS_EN
         chk($sformatf("stat_cnt[%0d]", i), stat_cnt_o[i*16 +: 16], exp_cnt[i]);
`else
         chk($sformatf("stat_cnt[%0d]", i), stat_cnt_o[i*16 +: 16], 0);
`endif
      end
   endtask

   task automatic check_drained(input string name);
      chk(name, q.size(), 0);
      q.delete();
   endtask

   // Monitor: compare every presented grant against the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (grant_o != '0) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_grant: got grant_o=%b id=%0d at cycle %0d, expected none",
                        grant_o, grant_id_o, cyc);
            end else begin
               e = q.pop_front();
               chk("grant_cycle", cyc, e.cyc);
               chk("grant_id", grant_id_o, e.id);
               chk("grant_onehot", grant_o, 1 << e.id);
            end
         end else begin
            chk("idle_grant_id", grant_id_o, 0);
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL missing_grant: got none at cycle %0d, expected id %0d at cycle %0d",
                        cyc, q[0].id, q[0].cyc);
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      req_i  = '0;
      rate_i = {NCH{8'd3}};
      cost_i = {NCH{8'd16}};
      tick(2);

      // Single requester, rate 3 cost 16: grants 1-9, gap 10-11, 12, then bucket=1 -> 17.
      do_reset();
      rate_i = {NCH{8'd3}};
      cost_i = {NCH{8'd16}};
      req_i  = 4'b0001;
      #1;
      chk("t1_ready_full", ready_o, 4'b1111);
      base = cyc;
      for (int k = 1; k <= 9; k++) expect_grant(base + k, 0);
      expect_grant(base + 12, 0);
      expect_grant(base + 17, 0);
      tick(12);
      chk("t1_ready0_after12", ready_o[0], 0);
      tick(5);
      req_i = '0;
      tick(2);
      check_drained("t1_drained");
      check_stats();

      // All four requesting from full: strict rotation with no gaps.
      do_reset();
      req_i = 4'b1111;
      base  = cyc;
      for (int k = 0; k < 16; k++) expect_grant(base + 1 + k, k % 4);
      tick(16);
      req_i = '0;
      tick(2);
      check_drained("t2_drained");
      check_stats();

      // ch2 with zero refill: exactly 8 grants drain the bucket.
      do_reset();
      rate_i[2*RATE_W +: RATE_W] = 8'd0;
      req_i = 4'b0100;
      #1;
      chk("t3_ready2_full", ready_o[2], 1);
      base = cyc;
      for (int k = 1; k <= 8; k++) expect_grant(base + k, 2);
      tick(8);
      chk("t3_ready2_empty", ready_o[2], 0);
      tick(4);
      chk("t3_ready2_still_empty", ready_o[2], 0);
      req_i = '0;
      tick(1);
      check_drained("t3_drained");
      check_stats();

      // ch1/ch3 contention from rr_ptr 0, then ch1 cost above TOK_MAX.
      do_reset();
      rate_i = {NCH{8'd3}};
      cost_i = {NCH{8'd16}};
      req_i  = 4'b1010;
      base   = cyc;
      expect_grant(base + 1, 1);
      expect_grant(base + 2, 3);
      tick(2);
      cost_i[1*COST_W +: COST_W] = 8'd200;
      req_i = 4'b0010;
      #1;
      chk("t4_ready1_overcost", ready_o[1], 0);
      chk("t4_ready3", ready_o[3], 1);
      tick(6);
      chk("t4_ready1_overcost_full", ready_o[1], 0);
      req_i = '0;
      tick(1);
      check_drained("t4_drained");
      check_stats();

      // Async reset mid-burst: grant drops at once, ch0 then drains a full bucket.
      do_reset();
      cost_i = {NCH{8'd16}};
      req_i  = 4'b1111;
      base   = cyc;
      expect_grant(base + 1, 0);
      tick(2);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_async_grant", grant_o, 0);
      chk("t5_async_grant_id", grant_id_o, 0);
      req_i = 4'b0001;
      rate_i[0 +: RATE_W] = 8'd0;
      for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) expect_grant(base + 2 + k, 0);
      tick(8);
      tick(3);
      chk("t5_ready0_empty", ready_o[0], 0);
      req_i = '0;
      tick(1);
      check_drained("t5_drained");
      check_stats();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_token_bucket.md
MC_TOKEN_BUCKET -- requirements
Module: mc_token_bucket

Interface
REQ-001 SHALL have parameter NCH, default 4: number of request channels.
REQ-002 SHALL have parameter DEN, default 16: tokens per nominal request.
REQ-003 SHALL have parameter BURST_MAX, default 8: bucket depth in nominal requests; TOK_MAX = BURST_MAX*DEN.
REQ-004 SHALL have parameter RATE_W, default 8: width of each per-channel refill rate.
REQ-005 SHALL have parameter COST_W, default 8: width of each per-channel request cost.
REQ-006 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port req_i, input, NCH: per-channel request level, sampled each rising edge.
REQ-009 SHALL have port rate_i, input, NCH*RATE_W: per-channel tokens added per cycle, channel i at bits [i*RATE_W +: RATE_W].
REQ-010 SHALL have port cost_i, input, NCH*COST_W: per-channel tokens consumed per grant, same packing.
REQ-011 SHALL have port grant_o, output, NCH: registered grant, at most one bit set.
REQ-012 SHALL have port grant_id_o, output, $clog2(NCH): index of the granted channel; 0 when grant_o is zero.
REQ-013 SHALL have port ready_o, output, NCH: combinational; bit i high when a request on channel i this cycle is eligible.
REQ-014 SHALL have port stat_cnt_o, output, NCH*16: per-channel grant counters.

Function
REQ-015 SHALL compute, each cycle and per channel, post = min(tokens_q + rate, TOK_MAX) in TOK_W+1 bits, where TOK_W = $clog2(TOK_MAX+1), so the add cannot wrap.
REQ-016 SHALL mark channel i eligible when req_i[i] is high and post_i >= cost_i; ready_o[i] is the same compare without the req_i term.
REQ-017 SHALL grant at most one eligible channel per edge, chosen round-robin from rr_ptr upward with wrap from NCH-1 to 0.
REQ-018 SHALL set rr_ptr to (granted index + 1) mod NCH on a grant; otherwise rr_ptr holds.
REQ-019 SHALL load post - cost into the granted channel at the edge and post into every other channel, including eligible losers.
REQ-020 SHALL assert grant_o and grant_id_o for exactly the cycle following the sampling edge (latency 1), low otherwise.
REQ-021 SHALL treat cost 0 as always eligible when requested, with no token change beyond the refill.
REQ-022 SHALL never grant a channel whose cost exceeds TOK_MAX, and SHALL hold its ready_o low.
REQ-023 SHALL take rate and cost changes into effect on the first edge at which they are sampled.

Reset
REQ-024 SHALL, while rst is high and independent of clk, set all buckets to TOK_MAX, rr_ptr to 0, grant_o and grant_id_o to 0, and counters to 0.
REQ-025 SHALL make the first edge after rst deasserts a normal accrue-and-decide cycle.

Configuration
REQ-026 SHALL, with TOKEN_BUCKET_STATS_EN defined, make stat_cnt_o hold per-channel grant counts that increment on each grant and saturate at 16'hFFFF.
REQ-027 SHALL, without TOKEN_BUCKET_STATS_EN, drive stat_cnt_o to constant 0, instantiate no counter flops, and keep the port list unchanged.

Structure
REQ-028 SHALL place TOK_W/TOK_MAX helper functions and the default parameter constants in package token_bucket_pkg.
REQ-029 SHALL implement each bucket (saturating accrue, compare, debit) in sub-module token_bucket_chan, instantiated NCH times; the arbiter and stats SHALL stay in the top.

Verification
REQ-030 SHALL cover: NCH=4, DEN=16, BURST_MAX=8, only ch0 requesting, rate 3, cost 16 -> grants on cycles 1-9, none on 10-11, grant on 12, and ch0's bucket is 1 after cycle 12.
REQ-031 SHALL cover: all four channels requesting from full, rate 3, cost 16 -> grant_id_o sequence 0,1,2,3,0,1,... with no gaps while all buckets stay >= 16.
REQ-032 SHALL cover: ch2 with rate 0, cost 16, requesting continuously -> exactly 8 grants, then none; ready_o[2] low afterward.
REQ-033 SHALL cover: ch1 and ch3 eligible with rr_ptr=0 -> ch1 granted, then ch3 on the next cycle; ch1 cost 200 (above TOK_MAX 128) -> ch1 never granted.
REQ-034 SHALL cover: rst pulsed mid-burst between clock edges -> grant_o 0 immediately; first post-reset grant goes to ch0 with a full bucket.
REQ-035 SHALL cover: with TOKEN_BUCKET_STATS_EN, stat_cnt_o matches the reference-model grant count per channel; without it, stat_cnt_o stays 0.
